// File: rtl/systolic_tile_scheduler_pkg.sv
// systolic_tile_scheduler_pkg
// Shared state encoding and tile-extent width rule.
package systolic_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    // A clipped extent ranges 1..2^log2, so it needs one extra bit
    function automatic int extent_w(input int log2);
        return log2 + 1;
    endfunction

endpackage

// File: rtl/tile_dim_counter.sv
// tile_dim_counter
// One tiling dimension: base, +K operand address, wrap flag, clipped extent.
module tile_dim_counter
    import systolic_tile_scheduler_pkg::*;
#(
    parameter int SIZE_W    = 9,
    parameter int STEP      = 32,
    parameter int STEP_LOG2 = 5,
    parameter int K_W       = 9,
    parameter int AW        = 10,
    parameter int EXT_W     = extent_w(STEP_LOG2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [K_W-1:0]    k_i,
    output logic [SIZE_W-1:0] base_o,
    output logic [AW-1:0]     addr_o,
    output logic [EXT_W-1:0]  extent_o,
    output logic              last_o
);

    logic [SIZE_W-1:0] base_q, base_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [SIZE_W-1:0] remain;
    logic [SIZE_W:0]   reach;

    // Next base/address: clear wins over advance
    always_comb begin
        base_d = base_q;
        addr_d = addr_q;
        if (clr_i) begin
            base_d = '0;
            addr_d = '0;
        end else if (adv_i) begin
            base_d = base_q + SIZE_W'(STEP);
            addr_d = addr_q + AW'(k_i);
        end
    end

    // Base and operand address registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

    // Wider sum so base+STEP cannot overflow before the compare
    assign reach    = {1'b0, base_q} + (SIZE_W+1)'(STEP);
    assign last_o   = (reach >= {1'b0, size_i});
    assign remain   = size_i - base_q;
    assign extent_o = (remain >= SIZE_W'(STEP)) ? EXT_W'(STEP)
                                                : EXT_W'(remain);
    assign base_o   = base_q;
    assign addr_o   = addr_q;

endmodule

// File: rtl/systolic_tile_scheduler.sv
// systolic_tile_scheduler
// Walks an MxKxN job as N-inner output tiles, one outstanding at a time.
module systolic_tile_scheduler
    import systolic_tile_scheduler_pkg::*;
#(
    parameter int PE_ARRAY_NUM_ROWS      = 32,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
    parameter int PE_ARRAY_NUM_COLS      = 32,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
    parameter int MAX_M_SIZE_LOG2        = 9,
    parameter int MAX_K_SIZE_LOG2        = 9,
    parameter int MAX_N_SIZE_LOG2        = 9,
    parameter int OPND1_SRAM_AWIDTH      = 10,
    parameter int OPND2_SRAM_AWIDTH      = 10,
    parameter int OUT_SRAM_AWIDTH        = 10
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                START,
    input  logic                                STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]          M_SIZE_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]          K_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]          N_SIZE_in,
    output logic                                TILE_VALID_out,
    input  logic                                TILE_READY_in,
    output logic [MAX_M_SIZE_LOG2-1:0]          TILE_M_BASE_out,
    output logic [MAX_N_SIZE_LOG2-1:0]          TILE_N_BASE_out,
    output logic [PE_ARRAY_NUM_ROWS_LOG2:0]     TILE_ROWS_out,
    output logic [PE_ARRAY_NUM_COLS_LOG2:0]     TILE_COLS_out,
    output logic [OPND1_SRAM_AWIDTH-1:0]        OPND1_BASE_out,
    output logic [OPND2_SRAM_AWIDTH-1:0]        OPND2_BASE_out,
    output logic [OUT_SRAM_AWIDTH-1:0]          OUT_BASE_out,
    input  logic                                TILE_DONE_in,
    output logic                                BUSY_out,
    output logic                                IS_FINISHED_out
);

    state_e                       state_q;
    logic [MAX_M_SIZE_LOG2-1:0]   m_size_q;
    logic [MAX_K_SIZE_LOG2-1:0]   k_size_q;
    logic [MAX_N_SIZE_LOG2-1:0]   n_size_q;
    logic [OUT_SRAM_AWIDTH-1:0]   out_base_q;
    logic                         valid_q;
    logic                         busy_q;
    logic                         fin_q;

    logic run, in_load, in_next;
    logic m_last, n_last;
    logic m_clr, m_adv, n_clr, n_adv;

    assign run     = !STALL;
    assign in_load = (state_q == ST_LOAD);
    assign in_next = (state_q == ST_NEXT);

    // Counters hold on the final tile so FINISH keeps its descriptor
    assign m_clr = run & in_load;
    assign m_adv = run & in_next & n_last & !m_last;
    assign n_clr = run & (in_load | (in_next & n_last & !m_last));
    assign n_adv = run & in_next & !n_last;

    tile_dim_counter #(
        .SIZE_W    (MAX_M_SIZE_LOG2),
        .STEP      (PE_ARRAY_NUM_ROWS),
        .STEP_LOG2 (PE_ARRAY_NUM_ROWS_LOG2),
        .K_W       (MAX_K_SIZE_LOG2),
        .AW        (OPND1_SRAM_AWIDTH)
    ) u_m_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (m_clr),
        .adv_i    (m_adv),
        .size_i   (m_size_q),
        .k_i      (k_size_q),
        .base_o   (TILE_M_BASE_out),
        .addr_o   (OPND1_BASE_out),
        .extent_o (TILE_ROWS_out),
        .last_o   (m_last)
    );

    tile_dim_counter #(
        .SIZE_W    (MAX_N_SIZE_LOG2),
        .STEP      (PE_ARRAY_NUM_COLS),
        .STEP_LOG2 (PE_ARRAY_NUM_COLS_LOG2),
        .K_W       (MAX_K_SIZE_LOG2),
        .AW        (OPND2_SRAM_AWIDTH)
    ) u_n_cnt (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (n_clr),
        .adv_i    (n_adv),
        .size_i   (n_size_q),
        .k_i      (k_size_q),
        .base_o   (TILE_N_BASE_out),
        .addr_o   (OPND2_BASE_out),
        .extent_o (TILE_COLS_out),
        .last_o   (n_last)
    );

    // Job FSM with registered handshake/status outputs and OUT_BASE accumulator
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            m_size_q   <= '0;
            k_size_q   <= '0;
            n_size_q   <= '0;
            out_base_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else if (run) begin
            unique case (state_q)
                ST_IDLE, ST_FINISH: begin
                    if (START) begin
                        state_q  <= ST_LOAD;
                        m_size_q <= M_SIZE_in;
                        k_size_q <= K_SIZE_in;
                        n_size_q <= N_SIZE_in;
                        busy_q   <= 1'b1;
                        fin_q    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    out_base_q <= '0;
                    if (m_size_q == '0 || k_size_q == '0 ||
                        n_size_q == '0) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (TILE_READY_in) begin
                        state_q <= ST_WAIT;
                        valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (TILE_DONE_in) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (m_last && n_last) begin
                        state_q <= ST_FINISH;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end else begin
                        state_q    <= ST_ISSUE;
                        valid_q    <= 1'b1;
                        out_base_q <= out_base_q +
                                      OUT_SRAM_AWIDTH'(PE_ARRAY_NUM_ROWS);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    fin_q   <= 1'b0;
                end
            endcase
        end
    end

    assign TILE_VALID_out  = valid_q;
    assign BUSY_out        = busy_q;
    assign IS_FINISHED_out = fin_q;
    assign OUT_BASE_out    = out_base_q;

endmodule
